// File: rtl/fwd_pkg.sv
// Shared types and defaults for the forwarding scoreboard.
// Entry metadata lives here; payload width is set by the top.
package fwd_pkg;

    localparam int DEF_XLEN  = 64;
    localparam int DEF_DEPTH = 8;
    localparam int TAG_W     = $clog2(DEF_DEPTH);

    typedef logic [4:0] reg_addr_t;

    // Data is kept in a separate XLEN-wide array so XLEN stays a free parameter.
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      ready;
    } fwd_entry_t;

    function automatic logic rd_match(input reg_addr_t a, input reg_addr_t b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match search for one operand port, with same-cycle result bypass.
// Scans backwards from tail-1 so the first valid hit is the youngest writer.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH,
    localparam int TW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]           valid,
    input  logic [DEPTH-1:0]           ready,
    input  logic [DEPTH-1:0][4:0]      rd,
    input  logic [DEPTH-1:0][XLEN-1:0] data,
    input  logic [TW-1:0]              tail,
    input  reg_addr_t                  rs,
    input  logic                       res_valid,
    input  logic [TW-1:0]              res_tag,
    input  logic [XLEN-1:0]            res_data,
    output logic                       hit,
    output logic                       stall,
    output logic [XLEN-1:0]            fwd
);

    logic          found;
    logic [TW-1:0] sel;
    logic [TW-1:0] idx;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail - TW'(1) - TW'(k);
            if (!found && valid[idx] && rd_match(rd[idx], rs)) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        hit   = found;
        stall = 1'b0;
        fwd   = '0;
        if (found) begin
            if (ready[sel]) begin
                fwd = data[sel];
            end else if (res_valid && res_tag == sel) begin
                fwd = res_data;
            end else begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-order writer table: allocates tags at decode, collects out-of-order
// results, retires in order and forwards youngest values to operand queries.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = 2,
    localparam int TW   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_valid,
    input  logic [4:0]                alloc_rd,
    output logic                      alloc_ready,
    output logic [TW-1:0]             alloc_tag,
    input  logic                      res_valid,
    input  logic [TW-1:0]             res_tag,
    input  logic [XLEN-1:0]           res_data,
    output logic                      wb_valid,
    output logic [4:0]                wb_rd,
    output logic [XLEN-1:0]           wb_data,
    input  logic                      wb_ready,
    input  logic                      flush,
    input  logic [NRD-1:0][4:0]       rs_addr,
    output logic [NRD-1:0]            fwd_hit,
    output logic [NRD-1:0][XLEN-1:0]  fwd_data,
    output logic [NRD-1:0]            fwd_stall,
    output logic                      stall_any,
    output logic [TW:0]               count
);

    fwd_entry_t      ent [DEPTH];
    logic [XLEN-1:0] dat [DEPTH];
    logic [TW-1:0]   head;
    logic [TW-1:0]   tail;
    logic [TW:0]     cnt;

    logic alloc_fire;
    logic retire;
    logic res_take;

    logic [DEPTH-1:0]           v_vec;
    logic [DEPTH-1:0]           r_vec;
    logic [DEPTH-1:0][4:0]      rd_vec;
    logic [DEPTH-1:0][XLEN-1:0] d_vec;

    // Full means the top count bit is set; never looks at this cycle's retire.
    assign alloc_ready = ~cnt[TW];
    assign alloc_tag   = tail;
    assign count       = cnt;
    assign alloc_fire  = alloc_valid & alloc_ready;

    assign wb_valid = ent[head].valid & ent[head].ready & ~flush;
    assign wb_rd    = ent[head].rd;
    assign wb_data  = dat[head];
    assign retire   = wb_valid & wb_ready;

    assign res_take = res_valid & ent[res_tag].valid & ~ent[res_tag].ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
                dat[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].ready <= 1'b0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (res_take) begin
                ent[res_tag].ready <= 1'b1;
                dat[res_tag]       <= res_data;
            end
            if (retire) begin
                ent[head].valid <= 1'b0;
                ent[head].ready <= 1'b0;
                head            <= head + TW'(1);
            end
            if (alloc_fire) begin
                ent[tail] <= '{valid: 1'b1, rd: alloc_rd, ready: 1'b0};
                dat[tail] <= '0;
                tail      <= tail + TW'(1);
            end
            unique case ({alloc_fire, retire})
                2'b10:   cnt <= cnt + (TW+1)'(1);
                2'b01:   cnt <= cnt - (TW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_vec[i]  = ent[i].valid;
            r_vec[i]  = ent[i].ready;
            rd_vec[i] = ent[i].rd;
            d_vec[i]  = dat[i];
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_port
        fwd_match #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH)
        ) u_match (
            .valid     (v_vec),
            .ready     (r_vec),
            .rd        (rd_vec),
            .data      (d_vec),
            .tail      (tail),
            .rs        (rs_addr[g]),
            .res_valid (res_valid),
            .res_tag   (res_tag),
            .res_data  (res_data),
            .hit       (fwd_hit[g]),
            .stall     (fwd_stall[g]),
            .fwd       (fwd_data[g])
        );
    end

    assign stall_any = |fwd_stall;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fwd_scoreboard;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int NRD   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     alloc_valid;
    logic [4:0]               alloc_rd;
    logic                     alloc_ready;
    logic [2:0]               alloc_tag;
    logic                     res_valid;
    logic [2:0]               res_tag;
    logic [XLEN-1:0]          res_data;
    logic                     wb_valid;
    logic [4:0]               wb_rd;
    logic [XLEN-1:0]          wb_data;
    logic                     wb_ready;
    logic                     flush;
    logic [NRD-1:0][4:0]      rs_addr;
    logic [NRD-1:0]           fwd_hit;
    logic [NRD-1:0][XLEN-1:0] fwd_data;
    logic [NRD-1:0]           fwd_stall;
    logic                     stall_any;
    logic [3:0]               count;

    int vecs = 0;
    int errs = 0;

    fwd_scoreboard #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .res_valid   (res_valid),
        .res_tag     (res_tag),
        .res_data    (res_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .flush       (flush),
        .rs_addr     (rs_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .fwd_stall   (fwd_stall),
        .stall_any   (stall_any),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model: ordered queue of in-flight writers, oldest first.
    typedef struct {
        logic [4:0]      rd;
        bit              rdy;
        logic [XLEN-1:0] data;
        int              tag;
    } m_ent_t;

    m_ent_t mq[$];
    int     mtail;

    typedef struct {
        bit              av;
        logic [4:0]      ard;
        bit              rv;
        logic [2:0]      rt;
        logic [XLEN-1:0] rdat;
        bit              wr;
        logic [4:0]      rs0;
        logic [4:0]      rs1;
        bit              e_ar;
        logic [2:0]      e_tag;
        logic [3:0]      e_cnt;
        bit              e_wv;
        logic [4:0]      e_wrd;
        logic [XLEN-1:0] e_wd;
        bit              e_h0;
        logic [XLEN-1:0] e_d0;
        bit              e_s0;
        bit              e_h1;
        logic [XLEN-1:0] e_d1;
        bit              e_s1;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        res_valid   = 1'b0;
        res_tag     = '0;
        res_data    = '0;
        wb_ready    = 1'b0;
        flush       = 1'b0;
        rs_addr[0]  = '0;
        rs_addr[1]  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mq.delete();
        mtail = 0;
    endtask

    task automatic m_query(input logic [4:0] rs, output bit h,
                           output logic [XLEN-1:0] d, output bit s);
        h = 0;
        s = 0;
        d = '0;
        if (rs != 0) begin
            for (int j = mq.size() - 1; j >= 0; j--) begin
                if (mq[j].rd == rs) begin
                    h = 1;
                    if (mq[j].rdy) d = mq[j].data;
                    else if (res_valid && int'(res_tag) == mq[j].tag) d = res_data;
                    else s = 1;
                    break;
                end
            end
        end
    endtask

    task automatic m_check();
        bit              h, s;
        bit              any_s;
        bit              ewv;
        logic [XLEN-1:0] d;
        any_s = 0;
        chk("rnd_alloc_ready", alloc_ready, mq.size() < DEPTH);
        chk("rnd_alloc_tag", alloc_tag, mtail);
        chk("rnd_count", count, mq.size());
        ewv = mq.size() > 0 && mq[0].rdy && !flush;
        chk("rnd_wb_valid", wb_valid, ewv);
        if (ewv) begin
            chk("rnd_wb_rd", wb_rd, mq[0].rd);
            chk("rnd_wb_data", wb_data, mq[0].data);
        end
        for (int p = 0; p < NRD; p++) begin
            m_query(rs_addr[p], h, d, s);
            any_s = any_s | s;
            chk("rnd_fwd_hit", fwd_hit[p], h);
            chk("rnd_fwd_data", fwd_data[p], d);
            chk("rnd_fwd_stall", fwd_stall[p], s);
        end
        chk("rnd_stall_any", stall_any, any_s);
    endtask

    task automatic m_update();
        bit ret;
        if (flush) begin
            mq.delete();
            mtail = 0;
            return;
        end
        ret = mq.size() > 0 && mq[0].rdy && wb_ready;
        if (res_valid) begin
            foreach (mq[j]) begin
                if (mq[j].tag == int'(res_tag) && !mq[j].rdy) begin
                    mq[j].rdy  = 1;
                    mq[j].data = res_data;
                end
            end
        end
        if (ret) void'(mq.pop_front());
        if (alloc_valid && mq.size() + (ret ? 1 : 0) < DEPTH) begin
            mq.push_back('{rd: alloc_rd, rdy: 0, data: '0, tag: mtail});
            mtail = (mtail + 1) % DEPTH;
        end
    endtask

    initial begin
        tbl[0]  = '{1, 5, 0, 0, 0,      0, 5, 0, 1, 0, 0, 0, 0, 0,      0, 0,      0, 0, 0,      0};
        tbl[1]  = '{0, 0, 0, 0, 0,      0, 5, 7, 1, 1, 1, 0, 0, 0,      1, 0,      1, 0, 0,      0};
        tbl[2]  = '{0, 0, 1, 0, 'h1234, 0, 5, 0, 1, 1, 1, 0, 0, 0,      1, 'h1234, 0, 0, 0,      0};
        tbl[3]  = '{0, 0, 0, 0, 0,      1, 5, 5, 1, 1, 1, 1, 5, 'h1234, 1, 'h1234, 0, 1, 'h1234, 0};
        tbl[4]  = '{1, 3, 0, 0, 0,      0, 5, 3, 1, 1, 0, 0, 0, 0,      0, 0,      0, 0, 0,      0};
        tbl[5]  = '{1, 3, 0, 0, 0,      0, 3, 0, 1, 2, 1, 0, 0, 0,      1, 0,      1, 0, 0,      0};
        tbl[6]  = '{0, 0, 1, 1, 'hA,    0, 3, 3, 1, 3, 2, 0, 0, 0,      1, 0,      1, 1, 0,      1};
        tbl[7]  = '{0, 0, 1, 2, 'hB,    0, 3, 0, 1, 3, 2, 1, 3, 'hA,    1, 'hB,    0, 0, 0,      0};
        tbl[8]  = '{0, 0, 1, 2, 'hC,    1, 3, 5, 1, 3, 2, 1, 3, 'hA,    1, 'hB,    0, 0, 0,      0};
        tbl[9]  = '{0, 0, 0, 0, 0,      1, 3, 0, 1, 3, 1, 1, 3, 'hB,    1, 'hB,    0, 0, 0,      0};
        tbl[10] = '{0, 0, 0, 0, 0,      0, 3, 3, 1, 3, 0, 0, 0, 0,      0, 0,      0, 0, 0,      0};

        idle();
        rst_n = 1'b0;
        #2;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_count", count, 0);
        chk("rst_wb_valid", wb_valid, 0);
        do_reset();

        // directed table: bypass, stall, youngest match, in-order retire
        for (int i = 0; i < 11; i++) begin
            alloc_valid = tbl[i].av;
            alloc_rd    = tbl[i].ard;
            res_valid   = tbl[i].rv;
            res_tag     = tbl[i].rt;
            res_data    = tbl[i].rdat;
            wb_ready    = tbl[i].wr;
            flush       = 1'b0;
            rs_addr[0]  = tbl[i].rs0;
            rs_addr[1]  = tbl[i].rs1;
            #2;
            chk("tbl_alloc_ready", alloc_ready, tbl[i].e_ar);
            chk("tbl_alloc_tag", alloc_tag, tbl[i].e_tag);
            chk("tbl_count", count, tbl[i].e_cnt);
            chk("tbl_wb_valid", wb_valid, tbl[i].e_wv);
            if (tbl[i].e_wv) begin
                chk("tbl_wb_rd", wb_rd, tbl[i].e_wrd);
                chk("tbl_wb_data", wb_data, tbl[i].e_wd);
            end
            chk("tbl_hit0", fwd_hit[0], tbl[i].e_h0);
            chk("tbl_data0", fwd_data[0], tbl[i].e_d0);
            chk("tbl_stall0", fwd_stall[0], tbl[i].e_s0);
            chk("tbl_hit1", fwd_hit[1], tbl[i].e_h1);
            chk("tbl_data1", fwd_data[1], tbl[i].e_d1);
            chk("tbl_stall1", fwd_stall[1], tbl[i].e_s1);
            chk("tbl_stall_any", stall_any, tbl[i].e_s0 | tbl[i].e_s1);
            tick();
        end

        // full table, retire while full does not admit an allocation
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i + 1);
            #2;
            chk("full_tag", alloc_tag, i);
            tick();
        end
        idle();
        #2;
        chk("full_count", count, 8);
        chk("full_ready", alloc_ready, 0);
        res_valid = 1'b1;
        res_tag   = 3'd0;
        res_data  = 64'h99;
        tick();
        idle();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        wb_ready    = 1'b1;
        #2;
        chk("full_wb_valid", wb_valid, 1);
        chk("full_ready_on_retire", alloc_ready, 0);
        tick();
        idle();
        #2;
        chk("full_count_after", count, 7);
        chk("full_tail_wrap", alloc_tag, 0);
        chk("full_ready_after", alloc_ready, 1);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        tick();
        idle();
        rs_addr[0] = 5'd9;
        rs_addr[1] = 5'd1;
        #2;
        chk("full_count_refill", count, 8);
        chk("full_new_stall", fwd_stall[0], 1);
        chk("full_retired_miss", fwd_hit[1], 0);

        // flush overrides alloc, result and retire
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            alloc_valid = 1'b1;
            alloc_rd    = 5'(10 + i);
            tick();
        end
        idle();
        res_valid = 1'b1;
        res_tag   = 3'd0;
        res_data  = 64'h55;
        tick();
        idle();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd13;
        res_valid   = 1'b1;
        res_tag     = 3'd1;
        res_data    = 64'h66;
        wb_ready    = 1'b1;
        flush       = 1'b1;
        #2;
        chk("flush_wb_gate", wb_valid, 0);
        tick();
        idle();
        rs_addr[0] = 5'd10;
        rs_addr[1] = 5'd13;
        #2;
        chk("flush_count", count, 0);
        chk("flush_tail", alloc_tag, 0);
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_miss0", fwd_hit[0], 0);
        chk("flush_miss1", fwd_hit[1], 0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd14;
        tick();
        idle();
        res_valid = 1'b1;
        res_tag   = 3'd0;
        res_data  = 64'h77;
        tick();
        idle();
        #2;
        chk("flush_head_zero", wb_valid, 1);
        chk("flush_head_rd", wb_rd, 14);

        // rd=0 never forwards; writeback holds under back-pressure
        do_reset();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd0;
        tick();
        idle();
        res_valid = 1'b1;
        res_tag   = 3'd0;
        res_data  = 64'h88;
        tick();
        idle();
        #2;
        chk("x0_hit0", fwd_hit[0], 0);
        chk("x0_hit1", fwd_hit[1], 0);
        chk("x0_wb_rd", wb_rd, 0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("hold_wb_valid", wb_valid, 1);
            chk("hold_count", count, 1);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        idle();
        #2;
        chk("hold_retired", count, 0);

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i + 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            res_valid = 1'b1;
            res_tag   = 3'(i);
            res_data  = 64'(100 + i);
            tick();
        end
        idle();
        rs_addr[0] = 5'd1;
        rs_addr[1] = 5'd4;
        #2;
        chk("pre_rst_hit", fwd_hit[0], 1);
        chk("pre_rst_stall", stall_any, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_alloc_ready", alloc_ready, 1);
        chk("arst_tag", alloc_tag, 0);
        chk("arst_count", count, 0);
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_hit", fwd_hit, 0);
        chk("arst_stall", fwd_stall, 0);
        chk("arst_stall_any", stall_any, 0);
        chk("arst_data0", fwd_data[0], 0);
        tick();
        tick();
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("arst_no_wb", wb_valid, 0);
            tick();
        end

        // random traffic against the queue model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_rd    = 5'($urandom_range(0, 7));
            res_valid   = 1'($urandom_range(0, 1));
            res_tag     = 3'($urandom_range(0, 7));
            res_data    = {$urandom, $urandom};
            wb_ready    = $urandom_range(0, 9) < 6;
            flush       = $urandom_range(0, 39) == 0;
            rs_addr[0]  = 5'($urandom_range(0, 7));
            rs_addr[1]  = 5'($urandom_range(0, 7));
            #2;
            m_check();
            m_update();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
